// File: rtl/sram_write_ctrl.sv
// Frame-buffer SRAM write sequencer: CASET/RASET window cursor, FWFT pixel FIFO, SWRESET clear sweep.
// Optional dropped-pixel counter enabled by defining SRAM_WRITE_CTRL_OVF_CNT_EN.
module sram_write_ctrl #(
   parameter int unsigned DISP_W     = 160,
   parameter int unsigned DISP_H     = 128,
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] CLR_COLOR  = 16'h0000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [31:0]       i_col_addr,
   input  logic [31:0]       i_row_addr,
   input  logic              i_waddr_set_req,
   input  logic              i_write_req,
   input  logic [15:0]       i_pixel_data,
   input  logic              i_clr_req,
   output logic              o_mem_wr,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [15:0]       o_mem_wdata,
   input  logic              i_mem_ready,
   output logic              o_busy,
   output logic              o_ovf,
   output logic [7:0]        o_ovf_cnt
);
   localparam int unsigned       PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned       CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]       X_MAX     = 16'(DISP_W - 1);
   localparam logic [15:0]       Y_MAX     = 16'(DISP_H - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(DISP_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DISP_W * DISP_H - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

   state_t            state_q, state_d;
   logic [15:0]       xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
   logic [15:0]       x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d, top_base_q, top_base_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [15:0]       fifo_data_q [FIFO_DEPTH];

   logic        fifo_empty, fifo_full, xfer, pop, push;
   logic [15:0] xs_clamp, xe_clamp, ys_clamp, ye_clamp;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_CNT);
   assign o_mem_wr   = (state_q == ST_CLEAR) | ~fifo_empty;
   assign xfer       = o_mem_wr & i_mem_ready;
   assign pop        = xfer & (state_q != ST_CLEAR);
   assign push       = i_write_req & (state_q == ST_IDLE) & (~fifo_full | pop);
   assign o_ovf      = i_write_req & ~push;
   assign o_busy     = (state_q != ST_IDLE) | ~fifo_empty;

   always_comb begin
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (state_q == ST_CLEAR) begin
         o_mem_addr  = clr_addr_q;
         o_mem_wdata = CLR_COLOR;
      end else if (!fifo_empty) begin
         o_mem_addr  = fifo_addr_q[rd_ptr_q];
         o_mem_wdata = fifo_data_q[rd_ptr_q];
      end
   end

   always_comb begin
      xs_clamp = (i_col_addr[31:16] > X_MAX) ? X_MAX : i_col_addr[31:16];
      xe_clamp = (i_col_addr[15:0]  > X_MAX) ? X_MAX : i_col_addr[15:0];
      ys_clamp = (i_row_addr[31:16] > Y_MAX) ? Y_MAX : i_row_addr[31:16];
      ye_clamp = (i_row_addr[15:0]  > Y_MAX) ? Y_MAX : i_row_addr[15:0];
      if (xs_clamp > xe_clamp) xe_clamp = xs_clamp;
      if (ys_clamp > ye_clamp) ye_clamp = ys_clamp;
   end

   always_comb begin
      state_d    = state_q;
      xs_d       = xs_q;
      xe_d       = xe_q;
      ys_d       = ys_q;
      ye_d       = ye_q;
      x_d        = x_q;
      y_d        = y_q;
      row_base_d = row_base_q;
      top_base_d = top_base_q;
      clr_addr_d = clr_addr_q;
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

      // The cursor moves even when the pixel is dropped on a full FIFO.
      if (i_write_req && state_q == ST_IDLE) begin
         if (x_q == xe_q) begin
            x_d = xs_q;
            if (y_q == ye_q) begin
               y_d        = ys_q;
               row_base_d = top_base_q;
            end else begin
               y_d        = y_q + 16'd1;
               row_base_d = row_base_q + ROW_STEP;
            end
         end else begin
            x_d = x_q + 16'd1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (i_clr_req) begin
               clr_addr_d = '0;
               state_d    = (count_d != '0) ? ST_DRAIN : ST_CLEAR;
            end
         end
         ST_DRAIN: begin
            if (count_d == '0) begin
               clr_addr_d = '0;
               state_d    = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (i_clr_req) begin
               clr_addr_d = '0;
            end else if (xfer) begin
               if (clr_addr_q == LAST_ADDR) begin
                  state_d    = ST_IDLE;
                  xs_d       = '0;
                  xe_d       = X_MAX;
                  ys_d       = '0;
                  ye_d       = Y_MAX;
                  x_d        = '0;
                  y_d        = '0;
                  row_base_d = '0;
                  top_base_d = '0;
               end else begin
                  clr_addr_d = clr_addr_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Latch last so a same-cycle write still uses the old cursor.
      if (i_waddr_set_req) begin
         xs_d       = xs_clamp;
         xe_d       = xe_clamp;
         ys_d       = ys_clamp;
         ye_d       = ye_clamp;
         x_d        = xs_clamp;
         y_d        = ys_clamp;
         top_base_d = ADDR_W'(ys_clamp) * ROW_STEP;
         row_base_d = ADDR_W'(ys_clamp) * ROW_STEP;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         xs_q       <= '0;
         xe_q       <= X_MAX;
         ys_q       <= '0;
         ye_q       <= Y_MAX;
         x_q        <= '0;
         y_q        <= '0;
         row_base_q <= '0;
         top_base_q <= '0;
         clr_addr_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         xs_q       <= xs_d;
         xe_q       <= xe_d;
         ys_q       <= ys_d;
         ye_q       <= ye_d;
         x_q        <= x_d;
         y_q        <= y_d;
         row_base_q <= row_base_d;
         top_base_q <= top_base_d;
         clr_addr_q <= clr_addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= row_base_q + ADDR_W'(x_q);
         fifo_data_q[wr_ptr_q] <= i_pixel_data;
      end
   end

`ifdef SRAM_WRITE_CTRL_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (o_ovf && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) ovf_cnt_q <= '0;
      else       ovf_cnt_q <= ovf_cnt_d;
   end

   assign o_ovf_cnt = ovf_cnt_q;
`else
   assign o_ovf_cnt = 8'h00;
`endif

endmodule

// File: doc/sram_write_ctrl.md
Name: sram_write_ctrl

Overview:
- Sequences all frame-buffer SRAM writes requested by the SPI command decoder.
- Holds the CASET/RASET window, auto-increments the write cursor per pixel and buffers pixels in a small FIFO.
- Runs the SWRESET full-clear sweep.
- Sits between the decoder and the SRAM port arbiter; presents one valid/ready write channel to the arbiter.

Parameters:
- DISP_W, 160, display width in pixels
- DISP_H, 128, display height in pixels
- ADDR_W, 15, SRAM word address width; must satisfy DISP_W*DISP_H <= 2**ADDR_W
- FIFO_DEPTH, 4, pixel FIFO entries; power of two
- CLR_COLOR, 16'h0000, pixel value written by the clear sweep

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_col_addr  in  32  XS[31:16], XE[15:0]
- i_row_addr  in  32  YS[31:16], YE[15:0]
- i_waddr_set_req  in  1  1-cycle pulse: latch window, home cursor
- i_write_req  in  1  1-cycle pulse: i_pixel_data valid
- i_pixel_data  in  16  RGB565 pixel
- i_clr_req  in  1  1-cycle pulse: start full clear
- o_mem_wr  out  1  write valid toward arbiter
- o_mem_addr  out  ADDR_W  word address, y*DISP_W+x
- o_mem_wdata  out  16  write data
- i_mem_ready  in  1  arbiter accepts; transfer = o_mem_wr & i_mem_ready
- o_busy  out  1  clear sweep active or FIFO non-empty
- o_ovf  out  1  1-cycle pulse: pixel dropped
- o_ovf_cnt  out  8  dropped-pixel count (optional feature)

Behaviour:
Reset values (i_rst high, asynchronous):
- o_mem_wr=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0, o_ovf=0, o_ovf_cnt=0.
- Window is full screen: xs=0, xe=DISP_W-1, ys=0, ye=DISP_H-1.
- Cursor x=0, y=0, row_base=0; FIFO empty; state IDLE.
- Reset mid-operation abandons any sweep and discards FIFO contents.

Window latch (on i_waddr_set_req):
- xs/xe are taken from i_col_addr[31:16]/[15:0]; ys/ye from i_row_addr likewise.
- Each value is clamped to DISP_W-1 (x) or DISP_H-1 (y).
- If xs>xe then xe:=xs; if ys>ye then ye:=ys.
- Cursor is set to (xs, ys) and row_base to ys*DISP_W, computed by a sequential add or a constant multiply.
- Every decoder CASET or RASET completion re-latches both registers.

Pixel write (on i_write_req, state IDLE):
- Push {row_base+x, i_pixel_data} into the FIFO, then advance the cursor.
- Cursor advance: if x==xe then x:=xs and advance the row, else x:=x+1.
- Row advance: if y==ye then y:=ys and row_base:=ys*DISP_W (wrap to window top), else y:=y+1 and row_base:=row_base+DISP_W.
- Address arithmetic is ADDR_W wide; no multiplier in the per-pixel path.

FIFO:
- First-word-fall-through. o_mem_wr = FIFO non-empty (IDLE), and head data/address drive o_mem_addr/o_mem_wdata.
- Latency: i_write_req at cycle N gives o_mem_wr=1 at N+1 when the FIFO was empty.
- Push and pop in the same cycle is allowed when the FIFO is full.
- A push into a full FIFO with no pop that cycle drops the pixel and pulses o_ovf. The cursor still advances, so the image geometry is preserved.
- While o_mem_wr=1 and i_mem_ready=0, o_mem_addr and o_mem_wdata hold stable.

State machine IDLE / DRAIN / CLEAR:
- IDLE -> DRAIN on i_clr_req when the FIFO is non-empty; IDLE -> CLEAR when it is empty.
- DRAIN: keeps popping the FIFO; when it is empty -> CLEAR with clr_addr=0.
- CLEAR: o_mem_wr=1, o_mem_addr=clr_addr, o_mem_wdata=CLR_COLOR. On each transfer clr_addr+1.
- The transfer at clr_addr==DISP_W*DISP_H-1 returns to IDLE.
- The clear also restores the full-screen window and homes the cursor at the end-of-sweep transfer.

Simultaneous events and edge cases:
- i_write_req while in DRAIN or CLEAR: pixel dropped and o_ovf pulses.
- i_clr_req during CLEAR: clr_addr:=0, sweep restarts.
- i_waddr_set_req with i_write_req in the same cycle: the write uses the old cursor, then the new window latches.
- i_clr_req with i_write_req in the same cycle: the write is accepted first (push), then the FSM enters DRAIN.
- o_busy = (state!=IDLE) | FIFO non-empty.

Optional Feature:
SRAM_WRITE_CTRL_OVF_CNT_EN:
- Defined: o_ovf_cnt increments on every o_ovf pulse, saturating at 8'hFF; it is cleared only by i_rst.
- Undefined: o_ovf_cnt is tied to 8'h00 and the counter logic is absent. o_ovf behaves identically in both builds.

Test Plan:
- Window set XS=2, XE=4, YS=1, YE=2, then 7 writes 16'h1000..16'h1006 with i_mem_ready=1 -> addresses 162,163,164,322,323,324,162 in order, data matching, o_ovf never set.
- Reset defaults, 1 write of 16'hABCD -> o_mem_wr high one cycle later with addr 0, data 16'hABCD; o_busy falls after the transfer.
- i_mem_ready held 0 and 6 writes with FIFO_DEPTH=4 -> 4 entries held with stable outputs, o_ovf pulses twice (o_ovf_cnt=2 with macro, 0 without). Releasing ready yields the first 4 pixels in order.
- XS=300, XE=10 (out of range) -> xs clamped to 159, xe:=159; 2 writes both at address y*160+159 for successive rows.
- 2 queued pixels, then i_clr_req -> both pixels transfer first, then 20480 writes of 16'h0000 at addr 0..20479; o_busy high throughout; state IDLE and cursor 0 afterwards.
- i_rst asserted mid-clear at clr_addr=1000 -> o_mem_wr=0 immediately (asynchronous), FIFO empty; after release a write goes to address 0.
